lsu_align: RTL
==============

// Module: lsu_align
// PURPOSE
//  Load/store unit between the rv32i core and the word-wide data RAM (mem_op_e, 1-cycle registered read).
//  Converts byte/half/word requests into whole-word RAM accesses.
//  Loads: lane extraction plus sign or zero extension.
//  Sub-word stores: read-modify-write, because the RAM writes only full words.
//  Misaligned or out-of-range requests are flagged and never reach the RAM.
// PARAMETERS
//  MEM_BYTES  4096  RAM size in bytes; req_addr >= MEM_BYTES is an error
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset_n      in   1   synchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE; request accepted on edge where req_valid & req_ready
//  req_we       in   1   1 = store, 0 = load
//  req_funct3   in   3   RV32I funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, LSB-aligned
//  resp_valid   out  1   one-cycle completion pulse
//  resp_rdata   out  32  load result; 0 for stores and errors
//  resp_err     out  1   misaligned / out-of-range / illegal funct3; valid with resp_valid
//  ram_addr     out  32  word address to RAM; bits [1:0] = 0
//  ram_wdata    out  32  full-word write data
//  ram_mem_op   out  mem_op_e  MEM_STORE writes; MEM_LOAD otherwise
//  ram_rdata    in   32  RAM read data, valid the cycle after the address is presented
// BEHAVIOUR
//  Reset
//   - state = IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; ram_addr=0; ram_wdata=0.
//   - ram_mem_op is forced to MEM_LOAD combinationally while reset_n=0.
//   - Hence no RAM write occurs on any edge where reset_n is sampled low, even mid-RMW.
//  Acceptance
//   - Request fields (we, funct3, addr, wdata) are latched on the accept edge E0.
//   - Inputs are ignored outside IDLE.
//  Error check at accept
//   - H/HU with addr[0]=1, or W with addr[1:0]!=0.
//   - addr >= MEM_BYTES.
//   - Load funct3 in {3,6,7}; store funct3 > 2.
//   - On error: E0 -> RESP, resp_err=1, resp_rdata=0; ram_mem_op stays MEM_LOAD.
//  FSM (states other than those below drive ram_mem_op = MEM_LOAD)
//   - IDLE -> LD_ADDR (load) | WR (store W) | RD (store B/H) | RESP (error).
//   - LD_ADDR: ram_addr={addr[31:2],2'b00}, MEM_LOAD -> LD_DATA.
//   - LD_DATA: ram_rdata valid; extract lane, register into resp_rdata -> RESP.
//   - RD: like LD_ADDR -> MERGE.
//   - MERGE: replace byte lane addr[1:0] (B) or half lane addr[1] (H) of ram_rdata with wdata[7:0] / [15:0];
//     register merged word -> WR.
//   - WR: ram_mem_op=MEM_STORE, ram_wdata = merged word or full wdata -> RESP.
//   - RESP: resp_valid=1 for exactly one cycle, req_ready=0 -> IDLE.
//  Extraction (loads)
//   - B: sign-extend byte lane addr[1:0]; BU: zero-extend that lane.
//   - H: sign-extend rdata[16*addr[1] +: 16]; HU: zero-extend that half.
//   - W: rdata unchanged.
//  Latency: accept edge to resp_valid-high cycle
//   - Error: 1 cycle. Word store: 2. Load: 3. Sub-word store: 4.
//  Throughput
//   - One outstanding request; next accept is possible in the cycle after RESP.
//   - Bytes outside the targeted lane(s) are never modified.
// TESTING
//  1 SW 0x100=0xDEADBEEF, then LW 0x100 -> resp_rdata=0xDEADBEEF, err=0; latencies 2 and 3 cycles.
//  2 SB 0x101=0xA5, then LW 0x100 -> 0xDEADA5EF; LB 0x101 -> 0xFFFFFFA5; LBU 0x101 -> 0x000000A5;
//    SB completes in 4 cycles.
//  3 SH 0x102=0x1234, then LW 0x100 -> 0x1234A5EF; LH 0x102 -> 0x00001234; LH 0x100 -> 0xFFFFA5EF;
//    LHU 0x100 -> 0x0000A5EF.
//  4 LW 0x102, SH 0x103, SW 0x1000 (MEM_BYTES=4096) -> each: resp_err=1, rdata=0, 1-cycle latency,
//    ram_mem_op never MEM_STORE; memory unchanged.
//  5 reset_n low for 1 cycle while in RD, MERGE or WR of SB 0x100=0x77 -> IDLE next cycle, no write,
//    LW 0x100 still 0x1234A5EF.
//  6 req_valid held high with 4 queued requests -> each accepted exactly once; req_ready low from
//    accept through RESP; exactly one resp_valid pulse per request.

Source files
------------

// File: rtl/lsu_align.sv
// lsu_align: turns RV32I byte/half/word loads and stores into whole-word accesses
// on a 1-cycle registered-read RAM; sub-word stores go through read-modify-write.
package mem_pkg;
  typedef enum logic {MEM_LOAD = 1'b0, MEM_STORE = 1'b1} mem_op_e;
endpackage

// state   | meaning
// IDLE    | waiting for a request, req_ready high
// LD_ADDR | load: word address on RAM
// LD_DATA | load: RAM data valid, lane extracted into resp_rdata
// RD      | sub-word store: read the target word
// MERGE   | sub-word store: splice new lane(s) into the read word
// WR      | store: full word written to RAM
// RESP    | one-cycle completion pulse
module lsu_align
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output mem_op_e     ram_mem_op,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_ADDR = 3'd1,
    LD_DATA = 3'd2,
    RD      = 3'd3,
    MERGE   = 3'd4,
    WR      = 3'd5,
    RESP    = 3'd6
  } state_e;

  state_e      state, state_nxt;
  logic [2:0]  f3_q;
  logic [1:0]  addr_lo_q;
  logic        accept;
  logic        req_err;
  logic [31:0] lane_shift;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  // Reset gates the write strobe directly so an in-flight RMW can never commit.
  assign ram_mem_op = (reset_n && state == WR) ? MEM_STORE : MEM_LOAD;

  always_comb begin
    req_err = 1'b0;
    if (req_addr >= 32'(MEM_BYTES))
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'd1 && req_addr[0])
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0)
      req_err = 1'b1;
    if (req_we) begin
      if (req_funct3 > 3'd2)
        req_err = 1'b1;
    end else if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                 state_nxt = RESP;
          else if (!req_we)            state_nxt = LD_ADDR;
          else if (req_funct3 == 3'd2) state_nxt = WR;
          else                         state_nxt = RD;
        end
      end
      LD_ADDR: state_nxt = LD_DATA;
      LD_DATA: state_nxt = RESP;
      RD:      state_nxt = MERGE;
      MERGE:   state_nxt = WR;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    lane_shift = ram_rdata >> {addr_lo_q, 3'b000};
    half_sel   = addr_lo_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (f3_q)
      3'd0:    load_val = {{24{lane_shift[7]}}, lane_shift[7:0]};
      3'd4:    load_val = {24'd0, lane_shift[7:0]};
      3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
      3'd5:    load_val = {16'd0, half_sel};
      default: load_val = ram_rdata;
    endcase
  end

  // ram_wdata still holds the LSB-aligned store data while in MERGE.
  always_comb begin
    merged = ram_rdata;
    if (f3_q[1:0] == 2'd0)
      merged[{addr_lo_q, 3'b000} +: 8] = ram_wdata[7:0];
    else
      merged[{addr_lo_q[1], 4'b0000} +: 16] = ram_wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      f3_q       <= 3'd0;
      addr_lo_q  <= 2'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      ram_addr   <= 32'd0;
      ram_wdata  <= 32'd0;
    end else begin
      if (accept) begin
        f3_q       <= req_funct3;
        addr_lo_q  <= req_addr[1:0];
        resp_err   <= req_err;
        resp_rdata <= 32'd0;
        if (!req_err) begin
          ram_addr <= {req_addr[31:2], 2'b00};
          if (req_we)
            ram_wdata <= req_wdata;
        end
      end
      if (state == LD_DATA)
        resp_rdata <= load_val;
      if (state == MERGE)
        ram_wdata <= merged;
    end
  end

endmodule
